lockin_demod: RTL and testbench
===============================

Name: lockin_demod

Overview:
- Lock-in demodulator that consumes the reference sine/cosine produced by the DDS NCO.
- Multiplies the ADC signal by the reference sin (I) and cos (Q), then integrates and dumps over 2^len_log2 samples.
- Emits averaged I/Q words through a valid/ready handshake toward the PID/locking logic.
- Sits between the ADC/NCO datapath and the lock controller.

Parameters:
- DATA_W, 16, width of signed signal and reference inputs
- MAX_LOG2, 16, maximum integration length exponent; accumulator width = 2*DATA_W + MAX_LOG2
- OUT_W, 32, width of signed averaged I/Q outputs

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  run demodulation; low forces IDLE
- len_log2  in  5  integration length exponent; values above MAX_LOG2 are clamped to MAX_LOG2
- in_valid  in  1  sig_in/sin_in/cos_in sample strobe
- sig_in  in  DATA_W  signed signal sample
- sin_in  in  DATA_W  signed reference sine from the NCO
- cos_in  in  DATA_W  signed reference cosine from the NCO
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- i_out  out  OUT_W  signed averaged in-phase result
- q_out  out  OUT_W  signed averaged quadrature result
- overrun  out  1  sticky flag: a result was overwritten before it was accepted

Behaviour:
- Reset: all outputs 0; accumulators, sample counter and pipeline registers 0; state IDLE.
- States:
  - IDLE → RUN when enable=1. On entry, latch the clamped len_log2 as L and clear the counter and accumulators.
  - RUN → IDLE when enable=0. The partial window is discarded and no result is issued.
  - A pending out_valid result is kept across RUN → IDLE until accepted.
- Stage 1 (registered): when in_valid=1, compute p_i = sig_in*sin_in and p_q = sig_in*cos_in as full 2*DATA_W signed products. Forward the valid bit with them.
- Stage 2:
  - On a valid product, add it to the sign-extended accumulators and increment the counter.
  - When the counter reaches 2^L - 1 and a valid product arrives, that product completes the window.
  - Next cycle: i_out/q_out = (acc + p) >>> L (arithmetic shift), truncated to OUT_W; out_valid=1.
  - In that same completion cycle, the accumulators restart at 0 and the counter at 0, so no sample is lost.
  - L is re-latched from len_log2 at each window start.
- Latency: last sample at in_valid (cycle t) gives out_valid at cycle t+2.
- L=0: every valid sample produces a result (average of one product).
- Handshake:
  - A transfer occurs on out_valid & out_ready.
  - out_valid drops the cycle after a transfer unless a new result lands in that same cycle, in which case it stays high with the new data.
  - i_out/q_out are stable while out_valid=1 and no new result completes.
- Overrun: if a new result completes while out_valid=1 and out_ready=0, the new data overwrites the old and overrun is set. overrun clears only on reset.
- in_valid=0 cycles: no accumulation and no counter change.
- Reset mid-window: everything is cleared asynchronously and the machine returns to IDLE.

Optional Feature:
- Macro LIA_MAG_EN.
- When defined:
  - Adds output port mag_out (OUT_W, unsigned) = max(|I|,|Q|) + (min(|I|,|Q|) >> 1), the alpha-max-beta-min estimate.
  - The abs/compare stage is registered, so out_valid is delayed by one cycle (t+3).
  - mag_out is aligned with i_out/q_out; handshake and overrun rules are unchanged.
  - |most-negative| saturates to the maximum positive value.
- When undefined: no mag_out port and latency is t+2.

Decomposition:
- Package lia_pkg:
  - ACC_W localparam function
  - state enum lia_state_t {IDLE, RUN}
  - clamp_len function
- Sub-module lia_mac (registered multiply, accumulate, dump-and-restart), instantiated twice: once for I, once for Q.
- Counter, state machine and handshake stay in lockin_demod.

Test Plan:
- DC correlation: len_log2=2; sig=sin=cos=16384 for 4 valid samples → one out_valid at t+2 with i_out=q_out=268435456.
- Quadrature: sig=sin sequence {16384,0,-16384,0} with cos {0,16384,0,-16384}, len_log2=2 → i_out=134217728, q_out=0.
- Backpressure: out_ready=0 across two completed windows → second result replaces the first, overrun=1; then out_ready=1 → single transfer, out_valid drops next cycle.
- Gaps and clamp: in_valid toggled every other cycle, len_log2=31 with MAX_LOG2=4 → result only after 16 valid samples.
- Mid-window disable/reset: enable=0 after 3 of 4 samples → no result; rst low mid-window → all outputs 0, state IDLE.
- LIA_MAG_EN: I=300, Q=-400 window → mag_out=400+150=550, out_valid at t+3.

Source files
------------

// File: rtl/lia_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lia_pkg : shared types and helpers for the lockin_demod lock-in      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lia_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lia_state_t;

  // Accumulator must absorb 2^MAX_LOG2 full-width products without overflow.
  function automatic int acc_w(input int data_w, input int max_log2);
    return 2 * data_w + max_log2;
  endfunction

  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_log2);
    logic [4:0] lim;
    lim = 5'(max_log2);
    return (len > lim) ? lim : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lia_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lia_mac : registered multiply, integrate and dump-with-restart        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lia_mac
  import lia_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 16,
  parameter int OUT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smp_valid,
  input  logic signed [DATA_W-1:0] sig_in,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic                     acc_en,
  input  logic                     clear,
  input  logic                     last,
  input  logic [4:0]               shift,
  output logic signed [OUT_W-1:0]  result
);

  localparam int ACC_W  = acc_w(DATA_W, MAX_LOG2);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [OUT_W-1:0]  result_d, result_q;

  always_comb begin
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (smp_valid) prod_d = sig_in * ref_in;
    prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    sum      = acc_q + prod_ext;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      // The closing product goes straight into the dump; the next window starts empty.
      if (last) begin
        acc_d    = '0;
        result_d = OUT_W'(sum >>> shift);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: rtl/lockin_demod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockin_demod : I/Q lock-in demodulator with integrate-and-dump and    |
// | valid/ready output. Define LIA_MAG_EN to add the mag_out estimate.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lockin_demod
  import lia_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 16,
  parameter int OUT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [4:0]               len_log2,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] sig_in,
  input  logic signed [DATA_W-1:0] sin_in,
  input  logic signed [DATA_W-1:0] cos_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  i_out,
  output logic signed [OUT_W-1:0]  q_out,
`ifdef LIA_MAG_EN
  output logic [OUT_W-1:0]         mag_out,
`endif
  output logic                     overrun
);

  localparam int CNT_W = MAX_LOG2 + 1;

  lia_state_t              state_d, state_q;
  logic [4:0]              len_d, len_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    p_valid_d, p_valid_q;
  logic                    out_valid_d, out_valid_q;
  logic                    overrun_d, overrun_q;
  logic                    acc_en, last, clear, done, new_res;
  logic signed [OUT_W-1:0] mac_i, mac_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    clear     = 1'b0;
    p_valid_d = in_valid & enable;
    acc_en    = p_valid_q && (state_q == RUN) && enable;
    last      = (cnt_q == ((CNT_W'(1) << len_q) - CNT_W'(1)));
    done      = acc_en && last;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          len_d   = clamp_len(len_log2, MAX_LOG2);
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (acc_en) begin
          if (last) begin
            cnt_d = '0;
            len_d = clamp_len(len_log2, MAX_LOG2);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lia_mac #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .OUT_W(OUT_W)) u_mac_i (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (in_valid),
    .sig_in    (sig_in),
    .ref_in    (sin_in),
    .acc_en    (acc_en),
    .clear     (clear),
    .last      (last),
    .shift     (len_q),
    .result    (mac_i)
  );

  lia_mac #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .OUT_W(OUT_W)) u_mac_q (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (in_valid),
    .sig_in    (sig_in),
    .ref_in    (cos_in),
    .acc_en    (acc_en),
    .clear     (clear),
    .last      (last),
    .shift     (len_q),
    .result    (mac_q)
  );

`ifdef LIA_MAG_EN
  logic                    done_q;
  logic signed [OUT_W-1:0] i_d, i_q, q_d, q_q;
  logic [OUT_W-1:0]        mag_d, mag_q, abs_i, abs_q;

  // Two's-complement minimum has no positive counterpart, so clip it.
  function automatic logic [OUT_W-1:0] abs_sat(input logic signed [OUT_W-1:0] v);
    if (!v[OUT_W-1]) return v;
    if (v[OUT_W-2:0] == '0) return {1'b0, {(OUT_W-1){1'b1}}};
    return -v;
  endfunction

  always_comb begin
    abs_i   = abs_sat(mac_i);
    abs_q   = abs_sat(mac_q);
    new_res = done_q;
    i_d     = i_q;
    q_d     = q_q;
    mag_d   = mag_q;
    if (done_q) begin
      i_d   = mac_i;
      q_d   = mac_q;
      mag_d = (abs_i > abs_q) ? abs_i + (abs_q >> 1) : abs_q + (abs_i >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
      mag_q  <= '0;
    end else begin
      done_q <= done;
      i_q    <= i_d;
      q_q    <= q_d;
      mag_q  <= mag_d;
    end
  end

  assign i_out   = i_q;
  assign q_out   = q_q;
  assign mag_out = mag_q;
`else
  assign new_res = done;
  assign i_out   = mac_i;
  assign q_out   = mac_q;
`endif

  // A landing result always wins; otherwise a transfer retires the held one.
  assign out_valid_d = new_res | (out_valid_q & ~out_ready);
  assign overrun_d   = overrun_q | (new_res & out_valid_q & ~out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      p_valid_q   <= p_valid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lockin_demod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lockin_demod : directed vectors for lockin_demod (MAX_LOG2 = 4)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lockin_demod;

  localparam int DATA_W   = 16;
  localparam int MAX_LOG2 = 4;
  localparam int OUT_W    = 32;
`ifdef LIA_MAG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                     clk       = 1'b0;
  logic                     rst       = 1'b1;
  logic                     enable    = 1'b0;
  logic                     in_valid  = 1'b0;
  logic                     out_ready = 1'b1;
  logic [4:0]               len_log2  = 5'd0;
  logic signed [DATA_W-1:0] sig_in    = '0;
  logic signed [DATA_W-1:0] sin_in    = '0;
  logic signed [DATA_W-1:0] cos_in    = '0;
  logic                     out_valid;
  logic                     overrun;
  logic signed [OUT_W-1:0]  i_out;
  logic signed [OUT_W-1:0]  q_out;
`ifdef LIA_MAG_EN
  logic [OUT_W-1:0]         mag_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int sig;
    int sn;
    int cs;
    int ei;
    int eq;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  lockin_demod #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .len_log2  (len_log2),
    .in_valid  (in_valid),
    .sig_in    (sig_in),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .i_out     (i_out),
    .q_out     (q_out),
`ifdef LIA_MAG_EN
    .mag_out   (mag_out),
`endif
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int s, input int sn, input int cs);
    sig_in   = 16'(s);
    sin_in   = 16'(sn);
    cos_in   = 16'(cs);
    in_valid = 1'b1;
    tick();
  endtask

  // Called right after the edge that captured the closing sample.
  task automatic expect_result(input string name, input int ei, input int eq);
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      check({name, "_early"}, out_valid, 0);
      tick();
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_i"}, i_out, ei);
    check({name, "_q"}, q_out, eq);
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 1, 1};
    tbl[1] = '{-3, 5, 7, -15, -21};
    tbl[2] = '{32767, 32767, -32768, 1073676289, -1073709056};
    tbl[3] = '{-32768, -32768, 32767, 1073741824, -1073709056};
    tbl[4] = '{1234, -2, 0, -2468, 0};
    tbl[5] = '{0, 12345, -1, 0, 0};

    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_i", i_out, 0);
    check("rst_q", q_out, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    // Single-sample windows (L = 0)
    len_log2 = 5'd0;
    enable   = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) begin
      send(tbl[n].sig, tbl[n].sn, tbl[n].cs);
      expect_result($sformatf("tbl%0d", n), tbl[n].ei, tbl[n].eq);
    end
    tick();
    check("tbl_drop", out_valid, 0);

    // DC correlation, L = 2
    enable = 1'b0;
    tick();
    len_log2 = 5'd2;
    enable   = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) send(16384, 16384, 16384);
    expect_result("dc", 268435456, 268435456);

    // Quadrature
    send(16384, 16384, 0);
    send(0, 0, 16384);
    send(-16384, -16384, 0);
    send(0, 0, -16384);
    expect_result("quad", 134217728, 0);
    tick();

    // Backpressure across two windows
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) send(16384, 16384, 16384);
    expect_result("bp_a", 268435456, 268435456);
    check("bp_a_overrun", overrun, 0);
    tick();
    tick();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_i", i_out, 268435456);
    send(16384, 16384, 0);
    send(0, 0, 16384);
    send(-16384, -16384, 0);
    send(0, 0, -16384);
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check("bp_b_valid", out_valid, 1);
    check("bp_b_i", i_out, 134217728);
    check("bp_b_q", q_out, 0);
    check("bp_b_overrun", overrun, 1);
    out_ready = 1'b1;
    tick();
    check("bp_drop", out_valid, 0);

    // Gapped samples with clamped length: 31 -> 4, so 16 samples
    enable = 1'b0;
    tick();
    len_log2 = 5'd31;
    enable   = 1'b1;
    tick();
    for (int n = 0; n < 15; n++) begin
      send(16384, 16384, 16384);
      in_valid = 1'b0;
      tick();
      check($sformatf("gap_none%0d", n), out_valid, 0);
    end
    send(16384, 16384, 16384);
    expect_result("gap", 268435456, 268435456);

    // Disable after 3 of 4 samples discards the partial window
    enable = 1'b0;
    tick();
    len_log2 = 5'd2;
    enable   = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) send(16384, 16384, 16384);
    in_valid = 1'b0;
    enable   = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    send(8192, 8192, 8192);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("dis_none%0d", k), out_valid, 0);
    end
    for (int n = 0; n < 3; n++) send(8192, 8192, 8192);
    expect_result("dis", 67108864, 67108864);
    tick();

    // Asynchronous reset mid-window
    check("ovr_sticky", overrun, 1);
    send(16384, 16384, 16384);
    send(16384, 16384, 16384);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_i", i_out, 0);
    check("arst_q", q_out, 0);
    check("arst_overrun", overrun, 0);
    #2 rst = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) send(-16384, 16384, -16384);
    expect_result("post_rst", -268435456, 268435456);
    tick();

    // Mixed-sign window: I = 300, Q = -400
    for (int n = 0; n < 4; n++) send(10, 30, -40);
    expect_result("magwin", 300, -400);
`ifdef LIA_MAG_EN
    check("mag", mag_out, 550);
`endif
    tick();
    check("magwin_drop", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
